vending_controller: RTL and testbench
=====================================

# vending_controller

Parametrised vending-machine transaction controller. Consumes debounced keypad events (one code per press), accumulates coin credit, handles product selection against per-product prices and stock, and issues vend and change pulses. It sits between the keypad/debounce front end and the binary-to-BCD / seven-segment display path, which it drives through a binary display value plus a display-mode code.

## Interface
Parameters:
- N_PRODUCTS, 4 — number of products, 1..10, selected by digit keys 0..N_PRODUCTS-1
- CREDIT_W, 8 — width of credit, price and change values
- MAX_CREDIT, 200 — credit ceiling; must be less than 2^CREDIT_W
- PRICE_LIST, {8'd50,8'd35,8'd25,8'd15} — packed N_PRODUCTS*CREDIT_W prices; product 0 in the LSBs
- STOCK_W, 4 — per-product stock counter width
- INIT_STOCK, 5 — stock loaded at reset and on restock
- MSG_CYCLES, 50_000_000 — hold time, in cycles, for error and sold-out messages

Ports:
- clk  in  1  — single clock
- reset  in  1  — asynchronous, active-low reset
- key_valid  in  1  — one-cycle strobe marking key_code as valid
- key_code  in  4  — 0x0-0x9 digit; 0xA coin 5; 0xB coin 10; 0xC coin 25; 0xD cancel; 0xE enter; 0xF deselect
- restock  in  1  — one-cycle pulse; loads every stock counter with INIT_STOCK
- vend  out  1  — one-cycle vend pulse
- vend_id  out  4  — product being vended; valid while vend is high, otherwise 0
- change_valid  out  1  — one-cycle change pulse
- change_amt  out  CREDIT_W  — change value; valid with change_valid, otherwise 0
- disp_value  out  CREDIT_W  — value to display
- disp_code  out  2  — 0 credit, 1 price, 2 sold out, 3 error
- busy  out  1  — high in VEND, CHANGE and MSG; keys are ignored while busy

## Operation
States are IDLE, SELECT, VEND, CHANGE and MSG. A key event is key_valid=1 sampled on a rising clk edge.

- **Reset:** state goes to IDLE. Credit and sel are 0, and every stock counter is INIT_STOCK. All pulse outputs are 0, disp_code is 0 and disp_value is 0.
- **Coin keys (IDLE, SELECT):** credit += coin value. If the sum would exceed MAX_CREDIT, credit is unchanged and the controller enters MSG with error.
- **Digit d (IDLE, SELECT):**
  - If d < N_PRODUCTS: sel = d, and the controller enters SELECT.
  - Otherwise: enter MSG with error.
- **Enter in IDLE:** ignored.
- **Enter in SELECT:**
  - If stock[sel] == 0: enter MSG with sold out.
  - Else if credit < price[sel]: enter MSG with error.
  - Otherwise: enter VEND.
- **Deselect (SELECT):** return to IDLE; credit is kept.
- **Cancel (IDLE, SELECT):** if credit > 0, enter CHANGE; otherwise go to IDLE.
- **VEND (one cycle):**
  - vend=1 and vend_id=sel.
  - stock[sel] decrements and credit -= price[sel].
  - Next state is CHANGE if the remaining credit is greater than 0, otherwise IDLE.
- **CHANGE (one cycle):** change_valid=1 and change_amt equals the current credit. Credit is then cleared to 0 and the state goes to IDLE.
- **MSG:** counts MSG_CYCLES cycles, then returns to the state it was entered from (IDLE or SELECT). Credit and sel are unchanged.
- **Display:**
  - IDLE: disp_value = credit, disp_code = 0.
  - SELECT: disp_value = price[sel], disp_code = 1.
  - MSG: disp_value = 0, disp_code = 2 or 3.
  - VEND and CHANGE: disp_value = credit, disp_code = 0.
- **Restock:** accepted in any state. If it coincides with a VEND decrement, restock wins and the counter loads INIT_STOCK.
- **Arithmetic:** credit arithmetic is unsigned CREDIT_W bits. Credit never wraps, because it is guarded by MAX_CREDIT, and it never underflows, because it is guarded by the price check. Stock never decrements below 0.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from key_code to any output.
- **Enter path:** a key event at edge N puts the controller in VEND during cycle N+1. vend is high for exactly cycle N+1. change_valid, if any, is high for exactly cycle N+2. The controller is back in IDLE at cycle N+3.
- **Cancel path:** Cancel at edge N gives change_valid in cycle N+1.
- **Coin path:** a coin at edge N is reflected on disp_value from cycle N+1.
- **Ignored keys:** key events during busy are dropped, not queued.
- **MSG duration:** MSG lasts exactly MSG_CYCLES cycles.
- **Reset mid-transaction:** reset asserted during any state clears state, credit and pulse outputs immediately. Credit is lost and no change pulse is issued.

## Structure
- Shared package `vend_pkg` holds:
  - key code constants (KEY_COIN5, KEY_COIN10, KEY_COIN25, KEY_CANCEL, KEY_ENTER, KEY_DESEL)
  - coin values
  - the state enum
  - the disp_code constants
- One natural sub-module, `vend_stock`: an array of N_PRODUCTS counters of STOCK_W bits with reset/restock load, a decrement by index, and a zero flag per product.

## Test plan
All scenarios use the default parameters.

1. **Exact payment:** reset; then C (+25), 1, E → vend=1 with vend_id=1 one cycle after E; no change_valid; credit 0; stock[1]=4.
2. **Vend with change:** C, C (credit 50), 0, E → vend with vend_id=0, then change_valid with change_amt=35 on the next cycle; then IDLE with disp_value=0.
3. **Credit ceiling:** 8×C → credit 200. A ninth C leaves credit at 200 and gives disp_code=3 for MSG_CYCLES cycles, then disp_code=0 with disp_value=200.
4. **Sold out and restock:** five vends of product 3, each paid with B×5, then a sixth E on product 3 → disp_code=2 and no vend. After restock, the vend succeeds.
5. **Rejected keys:**
   - digit 7 → error message.
   - E with credit 10 on product 0 (price 15) → error, then back to SELECT with credit still 10.
   - Cancel → change_amt=10.
6. **Reset mid-transaction and restock collision:** assert reset during CHANGE → change_valid drops at once and all outputs read 0. Separately, restock in the same cycle as a VEND leaves stock=INIT_STOCK.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine controller: key codes, coin values,
// FSM states and display-mode codes.
package vend_pkg;

    localparam logic [3:0] KEY_COIN5  = 4'hA;
    localparam logic [3:0] KEY_COIN10 = 4'hB;
    localparam logic [3:0] KEY_COIN25 = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;
    localparam logic [3:0] KEY_ENTER  = 4'hE;
    localparam logic [3:0] KEY_DESEL  = 4'hF;

    localparam int COIN5_VAL  = 5;
    localparam int COIN10_VAL = 10;
    localparam int COIN25_VAL = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_VEND,
        ST_CHANGE,
        ST_MSG
    } state_t;

    localparam logic [1:0] DISP_CREDIT   = 2'd0;
    localparam logic [1:0] DISP_PRICE    = 2'd1;
    localparam logic [1:0] DISP_SOLD_OUT = 2'd2;
    localparam logic [1:0] DISP_ERROR    = 2'd3;

    function automatic int coin_value(input logic [3:0] code);
        case (code)
            KEY_COIN5:  return COIN5_VAL;
            KEY_COIN10: return COIN10_VAL;
            KEY_COIN25: return COIN25_VAL;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-product stock counters: loaded at reset and on restock, decremented by index,
// with a sold-out flag per product. Restock takes priority over a decrement.
module vend_stock
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restock,
    input  logic                  dec_en,
    input  logic [IDX_W-1:0]      dec_idx,
    output logic [N_PRODUCTS-1:0] zero
);

    logic [STOCK_W-1:0] cnt [N_PRODUCTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PRODUCTS; i++) cnt[i] <= STOCK_W'(INIT_STOCK);
        end else if (restock) begin
            for (int i = 0; i < N_PRODUCTS; i++) cnt[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < N_PRODUCTS; i++) begin
                if (dec_en && dec_idx == IDX_W'(i) && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_PRODUCTS; g++) begin : g_zero
        assign zero[g] = (cnt[g] == '0);
    end

endmodule

// File: rtl/vending_controller.sv
// Vending transaction controller: coin credit, product selection, vend/change pulses
// and display drive. All outputs decode from registered state only.
//
// state     | meaning
// IDLE      | showing credit, accepting coins/digits/cancel
// SELECT    | product chosen, showing its price, accepting enter/deselect
// VEND      | one-cycle vend pulse, stock and credit deducted
// CHANGE    | one-cycle change pulse, credit cleared
// MSG       | timed sold-out/error message, returns to IDLE or SELECT
module vending_controller
    import vend_pkg::*;
#(
    parameter int                            N_PRODUCTS = 4,
    parameter int                            CREDIT_W   = 8,
    parameter int                            MAX_CREDIT = 200,
    parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICE_LIST = {8'd50, 8'd35, 8'd25, 8'd15},
    parameter int                            STOCK_W    = 4,
    parameter int                            INIT_STOCK = 5,
    parameter int                            MSG_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                restock,
    output logic                vend,
    output logic [3:0]          vend_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] disp_value,
    output logic [1:0]          disp_code,
    output logic                busy
);

    localparam int IDX_W = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1;
    localparam int TMR_W = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;
    localparam int N_PAD = 2 ** IDX_W;

    state_t              state, state_nxt, ret_state, ret_nxt;
    logic [CREDIT_W-1:0] credit, credit_nxt;
    logic [IDX_W-1:0]    sel, sel_nxt;
    logic [1:0]          msg_code, code_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                msg_req;
    logic [1:0]          msg_kind;

    logic [N_PRODUCTS-1:0]       stock_zero;
    logic [N_PAD-1:0]            zero_pad;
    logic [N_PAD*CREDIT_W-1:0]   price_pad;
    logic [CREDIT_W-1:0]         price_arr [N_PAD];
    logic [CREDIT_W-1:0]         price_sel;
    logic [CREDIT_W:0]           coin_sum;

    // Pad lookups to a power of two so sel can index them without range checks.
    assign zero_pad  = N_PAD'(stock_zero);
    assign price_pad = (N_PAD*CREDIT_W)'(PRICE_LIST);
    for (genvar g = 0; g < N_PAD; g++) begin : g_price
        assign price_arr[g] = price_pad[g*CREDIT_W +: CREDIT_W];
    end
    assign price_sel = price_arr[sel];
    assign coin_sum  = {1'b0, credit} + {1'b0, CREDIT_W'(coin_value(key_code))};

    vend_stock #(
        .N_PRODUCTS (N_PRODUCTS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK),
        .IDX_W      (IDX_W)
    ) u_stock (
        .clk     (clk),
        .reset   (reset),
        .restock (restock),
        .dec_en  (state == ST_VEND),
        .dec_idx (sel),
        .zero    (stock_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            credit    <= '0;
            sel       <= '0;
            msg_code  <= DISP_CREDIT;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            credit    <= credit_nxt;
            sel       <= sel_nxt;
            msg_code  <= code_nxt;
            timer     <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ret_nxt    = ret_state;
        credit_nxt = credit;
        sel_nxt    = sel;
        code_nxt   = msg_code;
        timer_nxt  = timer;
        msg_req    = 1'b0;
        msg_kind   = DISP_ERROR;
        case (state)
            ST_IDLE, ST_SELECT: begin
                if (key_valid) begin
                    case (key_code)
                        KEY_COIN5, KEY_COIN10, KEY_COIN25: begin
                            if (coin_sum > (CREDIT_W+1)'(MAX_CREDIT)) msg_req = 1'b1;
                            else credit_nxt = coin_sum[CREDIT_W-1:0];
                        end
                        KEY_CANCEL: state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
                        KEY_ENTER: begin
                            if (state == ST_SELECT) begin
                                if (zero_pad[sel]) begin
                                    msg_req  = 1'b1;
                                    msg_kind = DISP_SOLD_OUT;
                                end else if (credit < price_sel) begin
                                    msg_req = 1'b1;
                                end else begin
                                    state_nxt = ST_VEND;
                                end
                            end
                        end
                        KEY_DESEL: state_nxt = ST_IDLE;
                        default: begin
                            if (int'(key_code) < N_PRODUCTS) begin
                                sel_nxt   = IDX_W'(key_code);
                                state_nxt = ST_SELECT;
                            end else begin
                                msg_req = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_VEND: begin
                credit_nxt = credit - price_sel;
                state_nxt  = (credit != price_sel) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                credit_nxt = '0;
                state_nxt  = ST_IDLE;
            end
            ST_MSG: begin
                if (timer == '0) state_nxt = ret_state;
                else timer_nxt = timer - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (msg_req) begin
            state_nxt = ST_MSG;
            ret_nxt   = state;
            code_nxt  = msg_kind;
            timer_nxt = TMR_W'(MSG_CYCLES - 1);
        end
    end

    assign vend         = (state == ST_VEND);
    assign vend_id      = vend ? 4'(sel) : 4'd0;
    assign change_valid = (state == ST_CHANGE);
    assign change_amt   = change_valid ? credit : '0;
    assign busy         = (state == ST_VEND) || (state == ST_CHANGE) || (state == ST_MSG);

    always_comb begin
        disp_value = credit;
        disp_code  = DISP_CREDIT;
        case (state)
            ST_SELECT: begin
                disp_value = price_sel;
                disp_code  = DISP_PRICE;
            end
            ST_MSG: begin
                disp_value = '0;
                disp_code  = msg_code;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed scenarios with literal checks, then random
// key traffic, all outputs compared every cycle against a schedule-based model.
module tb_vending_controller;

    localparam int NP  = 4;
    localparam int MSG = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       restock = 1'b0;
    logic       vend;
    logic [3:0] vend_id;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] disp_value;
    logic [1:0] disp_code;
    logic       busy;

    int tests = 0;
    int fails = 0;

    vending_controller #(.MSG_CYCLES(MSG)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .restock      (restock),
        .vend         (vend),
        .vend_id      (vend_id),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .disp_value   (disp_value),
        .disp_code    (disp_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: each accepted key that starts a busy phase pushes one record per busy cycle.
    typedef struct {
        bit vend;
        int vend_id;
        bit chg;
        int chg_amt;
        int dval;
        int dcode;
        int dec;
    } rec_t;

    rec_t q[$];
    int   prices [NP] = '{15, 25, 35, 50};
    int   m_stock [NP];
    int   m_credit;
    int   m_sel;
    bit   m_selected;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t blank_rec();
        rec_t r;
        r.vend = 0; r.vend_id = 0; r.chg = 0; r.chg_amt = 0;
        r.dval = 0; r.dcode = 0; r.dec = -1;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_credit = 0;
        m_sel = 0;
        m_selected = 0;
        for (int i = 0; i < NP; i++) m_stock[i] = 5;
    endtask

    task automatic push_msg(input int kind);
        rec_t r = blank_rec();
        r.dcode = kind;
        for (int i = 0; i < MSG; i++) q.push_back(r);
    endtask

    task automatic push_change(input int amt);
        rec_t r = blank_rec();
        r.chg = 1; r.chg_amt = amt; r.dval = amt;
        q.push_back(r);
    endtask

    task automatic model_key(input int code);
        rec_t r;
        int   v;
        if (code >= 10 && code <= 12) begin
            v = (code == 10) ? 5 : (code == 11) ? 10 : 25;
            if (m_credit + v > 200) push_msg(3);
            else m_credit += v;
        end else if (code <= 9) begin
            if (code < NP) begin
                m_sel = code;
                m_selected = 1;
            end else begin
                push_msg(3);
            end
        end else if (code == 13) begin
            if (m_credit > 0) push_change(m_credit);
            m_credit = 0;
            m_selected = 0;
        end else if (code == 14 && m_selected) begin
            if (m_stock[m_sel] == 0) push_msg(2);
            else if (m_credit < prices[m_sel]) push_msg(3);
            else begin
                r = blank_rec();
                r.vend = 1; r.vend_id = m_sel; r.dval = m_credit; r.dec = m_sel;
                q.push_back(r);
                if (m_credit - prices[m_sel] > 0) push_change(m_credit - prices[m_sel]);
                m_credit = 0;
                m_selected = 0;
            end
        end else if (code == 15) begin
            m_selected = 0;
        end
    endtask

    task automatic model_step();
        bit was_busy = (q.size() > 0);
        if (!was_busy && key_valid) model_key(int'(key_code));
        if (restock) begin
            for (int i = 0; i < NP; i++) m_stock[i] = 5;
        end else if (was_busy && q[0].dec >= 0 && m_stock[q[0].dec] > 0) begin
            m_stock[q[0].dec]--;
        end
        if (was_busy) void'(q.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        rec_t r;
        #2;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q[0];
                check("busy", int'(busy), 1);
            end else begin
                r = blank_rec();
                r.dval  = m_selected ? prices[m_sel] : m_credit;
                r.dcode = m_selected ? 1 : 0;
                check("busy", int'(busy), 0);
            end
            check("vend", int'(vend), int'(r.vend));
            check("vend_id", int'(vend_id), r.vend_id);
            check("change_valid", int'(change_valid), int'(r.chg));
            check("change_amt", int'(change_amt), r.chg_amt);
            check("disp_value", int'(disp_value), r.dval);
            check("disp_code", int'(disp_code), r.dcode);
        end
    end

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] rand_key();
        int r = $urandom_range(0, 99);
        if (r < 35) return 4'(10 + $urandom_range(0, 2));
        if (r < 60) return 4'($urandom_range(0, 4));
        if (r < 80) return 4'hE;
        if (r < 88) return 4'hD;
        if (r < 94) return 4'hF;
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        wait_cycles(3);
        check("reset disp_value", int'(disp_value), 0);
        check("reset disp_code", int'(disp_code), 0);
        check("reset vend", int'(vend), 0);
        rst_n = 1'b1;

        // exact payment
        press(4'hC); press(4'h1); press(4'hE);
        check("exact vend", int'(vend), 1);
        check("exact vend_id", int'(vend_id), 1);
        wait_cycles(1);
        check("exact no change", int'(change_valid), 0);
        check("exact credit", int'(disp_value), 0);

        // vend with change
        press(4'hC); press(4'hC); press(4'h0); press(4'hE);
        check("chg vend_id", int'(vend_id), 0);
        check("chg vend disp", int'(disp_value), 50);
        wait_cycles(1);
        check("chg valid", int'(change_valid), 1);
        check("chg amt", int'(change_amt), 35);
        wait_cycles(1);
        check("chg idle disp", int'(disp_value), 0);

        // credit ceiling
        apply_reset();
        repeat (8) press(4'hC);
        check("ceil credit", int'(disp_value), 200);
        press(4'hC);
        check("ceil err", int'(disp_code), 3);
        wait_cycles(MSG - 1);
        check("ceil err held", int'(disp_code), 3);
        wait_cycles(1);
        check("ceil back code", int'(disp_code), 0);
        check("ceil back credit", int'(disp_value), 200);
        press(4'hD);
        check("ceil refund", int'(change_amt), 200);

        // sold out and restock
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            repeat (5) press(4'hB);
            press(4'h3); press(4'hE);
            check("so vend", int'(vend), 1);
            wait_cycles(3);
        end
        repeat (5) press(4'hB);
        press(4'h3); press(4'hE);
        check("so code", int'(disp_code), 2);
        check("so no vend", int'(vend), 0);
        wait_cycles(MSG);
        check("so back select", int'(disp_code), 1);
        check("so price", int'(disp_value), 50);
        @(negedge clk) restock = 1'b1;
        @(negedge clk) restock = 1'b0;
        press(4'hE);
        check("restock vend", int'(vend_id), 3);
        wait_cycles(3);

        // rejected keys
        apply_reset();
        press(4'h7);
        check("digit7 err", int'(disp_code), 3);
        wait_cycles(MSG);
        check("digit7 back", int'(disp_code), 0);
        press(4'hB); press(4'h0); press(4'hE);
        check("short err", int'(disp_code), 3);
        wait_cycles(MSG);
        check("short back", int'(disp_code), 1);
        check("short price", int'(disp_value), 15);
        press(4'hD);
        check("cancel valid", int'(change_valid), 1);
        check("cancel amt", int'(change_amt), 10);
        wait_cycles(2);

        // reset during CHANGE
        press(4'hC); press(4'hC); press(4'h0); press(4'hE);
        wait_cycles(1);
        check("pre-reset change", int'(change_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst change_valid", int'(change_valid), 0);
        check("rst change_amt", int'(change_amt), 0);
        check("rst disp_value", int'(disp_value), 0);
        check("rst busy", int'(busy), 0);
        @(negedge clk) rst_n = 1'b1;

        // restock coinciding with VEND: stock ends at 5, so five more vends then sold out
        press(4'hC); press(4'h0); press(4'hE);
        restock = 1'b1;
        @(negedge clk) restock = 1'b0;
        wait_cycles(2);
        for (int k = 0; k < 5; k++) begin
            press(4'hC); press(4'h0); press(4'hE);
            check("coll vend", int'(vend), 1);
            wait_cycles(3);
        end
        press(4'hC); press(4'h0); press(4'hE);
        check("coll sold out", int'(disp_code), 2);
        wait_cycles(MSG + 2);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) < 3) begin
                key_valid = 1'b0;
                restock   = 1'b0;
                rst_n     = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            key_valid = ($urandom_range(0, 2) == 0);
            key_code  = rand_key();
            restock   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        key_valid = 1'b0;
        restock   = 1'b0;
        wait_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
